// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction-fetch
// port and the load/store port. One outstanding memory transaction at a time,
// round-robin on ties, registered responses, per-transaction response watchdog.
module mem_port_arbiter #(
  parameter int DATAWIDTH = 32,
  parameter int TIMEOUT   = 255,
  parameter int CNTWIDTH  = 8
) (
  input  logic                 ARB_Clk_In,
  input  logic                 ARB_Reset_In,
  input  logic                 ARB_Ins_Req_In,
  input  logic [DATAWIDTH-1:0] ARB_Ins_Addr_InBUS,
  output logic                 ARB_Ins_Valid_Out,
  output logic [DATAWIDTH-1:0] ARB_Ins_Readdata_OutBUS,
  input  logic                 ARB_Dat_Req_In,
  input  logic                 ARB_Dat_We_In,
  input  logic [DATAWIDTH-1:0] ARB_Dat_Addr_InBUS,
  input  logic [3:0]           ARB_Dat_Byteenable_InBUS,
  input  logic [DATAWIDTH-1:0] ARB_Dat_Writedata_InBUS,
  output logic                 ARB_Dat_Valid_Out,
  output logic [DATAWIDTH-1:0] ARB_Dat_Readdata_OutBUS,
  output logic                 ARB_Err_Out,
  output logic                 MEM_Req_Out,
  output logic                 MEM_We_Out,
  output logic [DATAWIDTH-1:0] MEM_Addr_OutBUS,
  output logic [3:0]           MEM_Byteenable_OutBUS,
  output logic [DATAWIDTH-1:0] MEM_Writedata_OutBUS,
  input  logic                 MEM_Gnt_In,
  input  logic                 MEM_Rvalid_In,
  input  logic [DATAWIDTH-1:0] MEM_Readdata_InBUS
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IREQ  = 3'd1,
    IWAIT = 3'd2,
    DREQ  = 3'd3,
    DWAIT = 3'd4,
    DONE  = 3'd5
  } arbState_t;

  // Last cycle index of the wait window; unused when the watchdog is disabled.
  localparam logic [CNTWIDTH-1:0] WdLast = (TIMEOUT == 0) ? '0 : CNTWIDTH'(TIMEOUT - 1);

  arbState_t stateReg, stateNext;

  logic                 ownerDatReg;     // 1 = current transaction belongs to the data port
  logic                 lastGrantDatReg; // 1 = data port was served last
  logic                 errFlagReg;
  logic                 memReqReg;
  logic                 memWeReg;
  logic [DATAWIDTH-1:0] memAddrReg;
  logic [DATAWIDTH-1:0] memWdReg;
  logic [3:0]           memBeReg;
  logic [DATAWIDTH-1:0] insRdReg;
  logic [DATAWIDTH-1:0] datRdReg;
  logic [CNTWIDTH-1:0]  wdCntReg;

  logic pickIns, pickDat, timeoutHit;

  // Round-robin choice: a lone requester wins, a tie goes to the one not served last.
  assign pickIns    = ARB_Ins_Req_In && (!ARB_Dat_Req_In || lastGrantDatReg);
  assign pickDat    = ARB_Dat_Req_In && (!ARB_Ins_Req_In || !lastGrantDatReg);
  assign timeoutHit = (TIMEOUT != 0) && (wdCntReg == WdLast);

  // State register.
  always_ff @(posedge ARB_Clk_In) begin
    if (ARB_Reset_In) stateReg <= IDLE;
    else              stateReg <= stateNext;
  end

  // Next-state logic; requests are not looked at in DONE so a held request is not re-served.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: begin
        if (pickIns)      stateNext = IREQ;
        else if (pickDat) stateNext = DREQ;
      end
      IREQ:  if (MEM_Gnt_In) stateNext = MEM_Rvalid_In ? DONE : IWAIT;
      DREQ:  if (MEM_Gnt_In) stateNext = MEM_Rvalid_In ? DONE : DWAIT;
      IWAIT: if (MEM_Rvalid_In || timeoutHit) stateNext = DONE;
      DWAIT: if (MEM_Rvalid_In || timeoutHit) stateNext = DONE;
      DONE:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: latch the winner's command, track grant/response, run the watchdog.
  always_ff @(posedge ARB_Clk_In) begin
    if (ARB_Reset_In) begin
      ownerDatReg     <= 1'b0;
      lastGrantDatReg <= 1'b1;
      errFlagReg      <= 1'b0;
      memReqReg       <= 1'b0;
      memWeReg        <= 1'b0;
      memAddrReg      <= '0;
      memWdReg        <= '0;
      memBeReg        <= 4'b0000;
      insRdReg        <= '0;
      datRdReg        <= '0;
      wdCntReg        <= '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (pickIns) begin
            ownerDatReg <= 1'b0;
            memReqReg   <= 1'b1;
            memWeReg    <= 1'b0;
            memAddrReg  <= ARB_Ins_Addr_InBUS;
            memBeReg    <= 4'b1111;
            memWdReg    <= '0;
          end else if (pickDat) begin
            ownerDatReg <= 1'b1;
            memReqReg   <= 1'b1;
            memWeReg    <= ARB_Dat_We_In;
            memAddrReg  <= ARB_Dat_Addr_InBUS;
            memBeReg    <= ARB_Dat_Byteenable_InBUS;
            memWdReg    <= ARB_Dat_Writedata_InBUS;
          end
        end
        IREQ, DREQ: begin
          if (MEM_Gnt_In) begin
            memReqReg <= 1'b0;
            wdCntReg  <= '0;
            if (MEM_Rvalid_In) begin
              errFlagReg <= 1'b0;
              if (!ownerDatReg)   insRdReg <= MEM_Readdata_InBUS;
              else if (!memWeReg) datRdReg <= MEM_Readdata_InBUS;
            end
          end
        end
        IWAIT, DWAIT: begin
          if (MEM_Rvalid_In) begin
            errFlagReg <= 1'b0;
            if (!ownerDatReg)   insRdReg <= MEM_Readdata_InBUS;
            else if (!memWeReg) datRdReg <= MEM_Readdata_InBUS;
          end else if (timeoutHit) begin
            errFlagReg <= 1'b1;
            if (!ownerDatReg) insRdReg <= '0;
            else              datRdReg <= '0;
          end else begin
            wdCntReg <= wdCntReg + 1'b1;
          end
        end
        DONE: lastGrantDatReg <= ownerDatReg;
        default: ;
      endcase
    end
  end

  // Outputs: response strobes and error flag exist only in DONE.
  always_comb begin
    ARB_Ins_Valid_Out = 1'b0;
    ARB_Dat_Valid_Out = 1'b0;
    ARB_Err_Out       = 1'b0;
    if (stateReg == DONE) begin
      ARB_Ins_Valid_Out = !ownerDatReg;
      ARB_Dat_Valid_Out = ownerDatReg;
      ARB_Err_Out       = errFlagReg;
    end
  end

  assign ARB_Ins_Readdata_OutBUS = insRdReg;
  assign ARB_Dat_Readdata_OutBUS = datRdReg;
  assign MEM_Req_Out             = memReqReg;
  assign MEM_We_Out              = memWeReg;
  assign MEM_Addr_OutBUS         = memAddrReg;
  assign MEM_Byteenable_OutBUS   = memBeReg;
  assign MEM_Writedata_OutBUS    = memWdReg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a response scoreboard. Stimulus
// pushes the expected response; a negedge monitor pops and compares on each Valid.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        insReq;
  logic [31:0] insAddr;
  logic        insValid;
  logic [31:0] insRd;
  logic        datReq;
  logic        datWe;
  logic [31:0] datAddr;
  logic [3:0]  datBe;
  logic [31:0] datWd;
  logic        datValid;
  logic [31:0] datRd;
  logic        errOut;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [3:0]  memBe;
  logic [31:0] memWd;
  logic        memGnt;
  logic        memRvalid;
  logic [31:0] memRdata;

  // Manual memory drive, or a zero-wait responder returning addr ^ 0xA5A50000.
  logic        autoMem;
  logic        manGnt;
  logic        manRvalid;
  logic [31:0] manRdata;

  assign memGnt    = autoMem ? memReq : manGnt;
  assign memRvalid = autoMem ? memReq : manRvalid;
  assign memRdata  = autoMem ? (memAddr ^ 32'hA5A5_0000) : manRdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .DATAWIDTH(32),
    .TIMEOUT  (4),
    .CNTWIDTH (8)
  ) dut (
    .ARB_Clk_In              (clk),
    .ARB_Reset_In            (rst),
    .ARB_Ins_Req_In          (insReq),
    .ARB_Ins_Addr_InBUS      (insAddr),
    .ARB_Ins_Valid_Out       (insValid),
    .ARB_Ins_Readdata_OutBUS (insRd),
    .ARB_Dat_Req_In          (datReq),
    .ARB_Dat_We_In           (datWe),
    .ARB_Dat_Addr_InBUS      (datAddr),
    .ARB_Dat_Byteenable_InBUS(datBe),
    .ARB_Dat_Writedata_InBUS (datWd),
    .ARB_Dat_Valid_Out       (datValid),
    .ARB_Dat_Readdata_OutBUS (datRd),
    .ARB_Err_Out             (errOut),
    .MEM_Req_Out             (memReq),
    .MEM_We_Out              (memWe),
    .MEM_Addr_OutBUS         (memAddr),
    .MEM_Byteenable_OutBUS   (memBe),
    .MEM_Writedata_OutBUS    (memWd),
    .MEM_Gnt_In              (memGnt),
    .MEM_Rvalid_In           (memRvalid),
    .MEM_Readdata_InBUS      (memRdata)
  );

  typedef struct {
    logic        isDat;
    logic [31:0] data;
    logic        err;
  } expResp_t;

  expResp_t expQ[$];
  int tests  = 0;
  int errors = 0;
  int grantCnt = 0;
  int insSeen, datSeen;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic isDat, input logic [31:0] data, input logic err);
    expResp_t e;
    e.isDat = isDat;
    e.data  = data;
    e.err   = err;
    expQ.push_back(e);
  endtask

  // Hold both requests and drop each once it has been served the given number of times.
  task automatic serveBoth(input int nIns, input int nDat);
    insSeen = 0;
    datSeen = 0;
    insReq  = 1'b1;
    datReq  = 1'b1;
    for (int c = 0; c < 60 && (insReq || datReq); c++) begin
      step();
      if (insValid) begin
        insSeen++;
        if (insSeen == nIns) insReq = 1'b0;
      end
      if (datValid) begin
        datSeen++;
        if (datSeen == nDat) datReq = 1'b0;
      end
    end
    check("serve_ins_count", 128'(insSeen), 128'(nIns));
    check("serve_dat_count", 128'(datSeen), 128'(nDat));
    insReq = 1'b0;
    datReq = 1'b0;
  endtask

  // Counts memory-side handshakes.
  always @(posedge clk) begin
    if (!rst && memReq && memGnt) grantCnt++;
  end

  // Scoreboard monitor: compare each response strobe against the head of the queue.
  always @(negedge clk) begin
    expResp_t e;
    if (!rst) begin
      if (insValid && datValid) begin
        tests++;
        errors++;
        $display("[TB] FAIL valid_overlap: got ins=1 dat=1 expected at most one");
      end
      if (errOut && !insValid && !datValid) begin
        tests++;
        errors++;
        $display("[TB] FAIL err_without_valid: got err=1 expected 0");
      end
      if (insValid || datValid) begin
        if (expQ.size() == 0) begin
          tests++;
          errors++;
          $display("[TB] FAIL unexpected_valid: got ins=%0b dat=%0b expected none", insValid, datValid);
        end else begin
          e = expQ.pop_front();
          $display("[TB] resp %s data=%08h err=%0b", datValid ? "dat" : "ins",
                   datValid ? datRd : insRd, errOut);
          check("resp_port", 128'(datValid), 128'(e.isDat));
          check("resp_data", 128'(datValid ? datRd : insRd), 128'(e.data));
          check("resp_err", 128'(errOut), 128'(e.err));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int g0;
    rst = 1'b1;
    insReq = 1'b0; insAddr = '0;
    datReq = 1'b0; datWe = 1'b0; datAddr = '0; datBe = 4'h0; datWd = '0;
    autoMem = 1'b0; manGnt = 1'b0; manRvalid = 1'b0; manRdata = '0;
    step();
    step();
    check("reset_core_outs", {insValid, insRd, datValid, datRd, errOut}, '0);
    check("reset_mem_outs", {memReq, memWe, memAddr, memBe, memWd}, '0);
    rst = 1'b0;
    step();

    // Fetch only, Gnt at cycle 1, Rvalid at cycle 3, Valid at cycle 4.
    insReq = 1'b1; insAddr = 32'h0000_0010;
    pushExp(1'b0, 32'h0000_0013, 1'b0);
    step();
    check("fetch_mem_bus", {memReq, memWe, memAddr, memBe, memWd},
          {1'b1, 1'b0, 32'h0000_0010, 4'b1111, 32'h0});
    manGnt = 1'b1;
    step();
    manGnt = 1'b0;
    check("fetch_req_drop", 128'(memReq), 128'(0));
    step();
    manRvalid = 1'b1; manRdata = 32'h0000_0013;
    check("fetch_no_early_valid", 128'(insValid), 128'(0));
    step();
    manRvalid = 1'b0;
    check("fetch_valid_cycle4", {insValid, insRd, errOut}, {1'b1, 32'h0000_0013, 1'b0});
    insReq = 1'b0;
    step();
    check("fetch_valid_one_cycle", 128'(insValid), 128'(0));

    // Simultaneous requests after reset, zero-wait memory: I, D, I, D, I, D.
    rst = 1'b1;
    step();
    rst = 1'b0;
    autoMem = 1'b1;
    insAddr = 32'h0000_0040;
    datAddr = 32'h0000_0080; datWe = 1'b0; datBe = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      pushExp(1'b0, 32'hA5A5_0040, 1'b0);
      pushExp(1'b1, 32'hA5A5_0080, 1'b0);
    end
    serveBoth(3, 3);
    autoMem = 1'b0;
    step();

    // Store with grant withheld 5 cycles; load register must stay at 0xA5A50080.
    datReq = 1'b1; datWe = 1'b1; datAddr = 32'h0000_0100; datBe = 4'b0011; datWd = 32'hDEAD_BEEF;
    pushExp(1'b1, 32'hA5A5_0080, 1'b0);
    step();
    datWe = 1'b0; datAddr = 32'h0000_0FFF; datBe = 4'b1100; datWd = 32'h0;
    for (int k = 0; k < 5; k++) begin
      check("store_bus_stable", {memReq, memWe, memAddr, memBe, memWd},
            {1'b1, 1'b1, 32'h0000_0100, 4'b0011, 32'hDEAD_BEEF});
      step();
    end
    manGnt = 1'b1;
    step();
    manGnt = 1'b0;
    check("store_req_drop", 128'(memReq), 128'(0));
    manRvalid = 1'b1; manRdata = 32'h1234_5678;
    step();
    manRvalid = 1'b0;
    check("store_ack", {datValid, datRd, errOut}, {1'b1, 32'hA5A5_0080, 1'b0});
    datReq = 1'b0;
    step();

    // Watchdog: grant, no Rvalid; Err on the cycle after the 4th wait cycle.
    insReq = 1'b1; insAddr = 32'h0000_0200;
    pushExp(1'b0, 32'h0, 1'b1);
    step();
    manGnt = 1'b1;
    step();
    manGnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("timeout_waiting", 128'(insValid), 128'(0));
      step();
    end
    check("timeout_valid", {insValid, insRd, errOut}, {1'b1, 32'h0, 1'b1});
    insReq = 1'b0;
    step();
    manRvalid = 1'b1; manRdata = 32'hBAD0_BAD0;
    step();
    manRvalid = 1'b0;
    step();
    check("late_rvalid_ignored", {insValid, datValid, insRd}, {1'b0, 1'b0, 32'h0});

    // Reset in DWAIT aborts; later Rvalid ignored; fetch then wins the tie.
    datReq = 1'b1; datWe = 1'b0; datAddr = 32'h0000_0300; datBe = 4'b1111;
    step();
    manGnt = 1'b1;
    step();
    manGnt = 1'b0;
    step();
    rst = 1'b1; datReq = 1'b0;
    step();
    check("midreset_core_outs", {insValid, insRd, datValid, datRd, errOut}, '0);
    check("midreset_mem_outs", {memReq, memWe, memAddr, memBe, memWd}, '0);
    rst = 1'b0;
    manRvalid = 1'b1; manRdata = 32'h5555_AAAA;
    step();
    manRvalid = 1'b0;
    step();
    check("postreset_rvalid_ignored", {insValid, datValid, datRd, memReq}, '0);
    autoMem = 1'b1;
    insAddr = 32'h0000_0500; datAddr = 32'h0000_0600;
    pushExp(1'b0, 32'hA5A5_0500, 1'b0);
    pushExp(1'b1, 32'hA5A5_0600, 1'b0);
    serveBoth(1, 1);
    autoMem = 1'b0;
    step();

    // Request held through the Valid cycle must not be served twice.
    g0 = grantCnt;
    insReq = 1'b1; insAddr = 32'h0000_0400;
    pushExp(1'b0, 32'h0000_0077, 1'b0);
    step();
    manGnt = 1'b1; manRvalid = 1'b1; manRdata = 32'h0000_0077;
    step();
    manGnt = 1'b0; manRvalid = 1'b0;
    check("held_valid", 128'(insValid), 128'(1));
    step();
    insReq = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("held_single_txn", 128'(grantCnt - g0), 128'(1));
    check("held_no_mem_req", 128'(memReq), 128'(0));

    step();
    check("scoreboard_empty", 128'(expQ.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory interface between the core's instruction-fetch port and its load/store port.
- Two requesters, one outstanding memory transaction at a time.
- Round-robin arbitration, registered responses, per-transaction timeout watchdog.
- Sits between the multi-cycle core and a unified instruction/data memory. Core-facing handshakes are request-level/hold-until-valid.

Parameters:
- DATAWIDTH, 32, address/data width
- TIMEOUT, 255, max cycles waiting for MEM_Rvalid_In after grant; 0 disables watchdog
- CNTWIDTH, 8, watchdog counter width; must satisfy 2^CNTWIDTH > TIMEOUT

Ports:
- ARB_Clk_In  in  1  clock, all logic on rising edge
- ARB_Reset_In  in  1  reset, synchronous, active-high
- ARB_Ins_Req_In  in  1  fetch request, held until ARB_Ins_Valid_Out
- ARB_Ins_Addr_InBUS  in  DATAWIDTH  fetch address
- ARB_Ins_Valid_Out  out  1  one-cycle fetch response strobe
- ARB_Ins_Readdata_OutBUS  out  DATAWIDTH  fetched word, registered
- ARB_Dat_Req_In  in  1  data request, held until ARB_Dat_Valid_Out
- ARB_Dat_We_In  in  1  1=store, 0=load
- ARB_Dat_Addr_InBUS  in  DATAWIDTH  data address
- ARB_Dat_Byteenable_InBUS  in  4  store byte lanes
- ARB_Dat_Writedata_InBUS  in  DATAWIDTH  store data
- ARB_Dat_Valid_Out  out  1  one-cycle data response strobe (load data or store ack)
- ARB_Dat_Readdata_OutBUS  out  DATAWIDTH  load word, registered
- ARB_Err_Out  out  1  high with a Valid strobe when that transaction timed out
- MEM_Req_Out  out  1  memory request, registered
- MEM_We_Out  out  1  memory write enable
- MEM_Addr_OutBUS  out  DATAWIDTH  memory address
- MEM_Byteenable_OutBUS  out  4  byte lanes; 4'b1111 for fetches
- MEM_Writedata_OutBUS  out  DATAWIDTH  write data
- MEM_Gnt_In  in  1  memory accepted request this cycle
- MEM_Rvalid_In  in  1  memory response (read data or write ack)
- MEM_Readdata_InBUS  in  DATAWIDTH  memory read data

Behaviour:
- Reset: synchronous and active-high. Every output is 0. FSM goes to IDLE, watchdog counter is 0, and last_grant=DATA so the first tie goes to fetch. Reset asserted mid-transaction aborts it: no Valid is issued and later MEM_Rvalid_In is ignored while in IDLE.
- FSM states: IDLE, IREQ, IWAIT, DREQ, DWAIT, DONE.
- IDLE:
  - only Ins_Req -> IREQ.
  - only Dat_Req -> DREQ.
  - both -> the requester that is not last_grant.
  - Address, We, Byteenable and Writedata are latched into the MEM_* registers on the transition. MEM_Req_Out rises the next cycle (request-to-memory latency = 1 cycle).
  - Fetch: MEM_We_Out=0, MEM_Byteenable_OutBUS=4'b1111, MEM_Writedata_OutBUS=0.
- IREQ/DREQ:
  - MEM_Req_Out=1 and the MEM_* buses are held stable until MEM_Gnt_In=1.
  - On Gnt: -> IWAIT/DWAIT, MEM_Req_Out=0 from the next cycle, watchdog cleared.
  - Gnt and Rvalid in the same cycle: skip straight to DONE.
  - No timeout while waiting for grant.
- IWAIT/DWAIT:
  - The watchdog increments each cycle without MEM_Rvalid_In.
  - On MEM_Rvalid_In: capture MEM_Readdata_InBUS into the owning requester's Readdata register (loads and fetches only; a store leaves the register unchanged), Err=0, -> DONE.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no Rvalid: Readdata register=0, Err=1, -> DONE.
- DONE:
  - For exactly one cycle, assert the owner's Valid_Out; ARB_Err_Out carries the error flag.
  - last_grant is updated to the owner.
  - Requests are ignored in DONE so a requester still holding Req this cycle is not re-served.
  - -> IDLE.
  - ARB_Err_Out is 0 except in DONE.
  - Minimum transaction: Req sampled at cycle N, MEM_Req_Out at N+1, Gnt+Rvalid at N+1, Valid at N+2, next IDLE arbitration at N+3.
- MEM_Rvalid_In outside WAIT/REQ-with-Gnt: ignored.
- A requester dropping Req before its Valid: the transaction completes and Valid is still pulsed.
- Readdata registers hold their value until the next response for that port.
- Ins and Dat Valid are never high in the same cycle.

Test Plan:
- Fetch only: addr 0x0000_0010, Gnt at cycle 1, Rvalid=1 with 0x0000_0013 at cycle 3 -> Ins_Valid one cycle at cycle 4, Readdata=0x0000_0013, MEM_Byteenable=4'b1111, MEM_We=0, Err=0.
- Simultaneous Ins_Req and Dat_Req after reset, both held, memory with zero wait (Gnt+Rvalid together):
  - fetch is served first, then the data request.
  - Requests re-asserted at once: next grants alternate Ins, Dat, Ins.
  - No Ins_Valid/Dat_Valid overlap.
- Store: addr 0x100, We=1, Byteenable=4'b0011, data 0xDEAD_BEEF -> MEM_* buses match and are stable while Gnt is withheld for 5 cycles; Dat_Valid pulses one cycle after Rvalid; Dat_Readdata unchanged.
- Timeout, TIMEOUT=4: fetch granted, Rvalid never asserted -> Ins_Valid with Err=1 and Readdata=0 on the cycle after the 4th wait cycle. A late Rvalid afterward produces no extra Valid.
- Reset asserted during DWAIT -> all outputs 0 next cycle, FSM in IDLE. A subsequent Rvalid is ignored. A new fetch wins a tie against a data request (last_grant=DATA).
- Held request after DONE: Ins_Req kept high for one cycle past Ins_Valid, then dropped -> exactly one memory transaction issued.
